// File: rtl/dsp_bypass_split_pkg.sv
// Shared definitions for the bypassable-filter input splitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no flow control in this package).
package dsp_bypass_split_pkg;

  // Path-select FSM states; encoding is fixed so other DSP blocks can decode it.
  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_PRIME  = 2'd1,
    ST_FILTER = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // Latency counter width: one extra bit so DELAY itself (up to 2^LGDELAY) fits.
  function automatic int cnt_width(input int lgdelay);
    return lgdelay + 1;
  endfunction

endpackage

// File: rtl/dsp_sample_delay.sv
// CE-gated, zero-filled sample delay line for path alignment.
// Latency: o_sample shows the sample accepted DELAY strobes earlier.
// Backpressure: none; advances only on i_ce and holds otherwise.
module dsp_sample_delay #(
  parameter int DW    = 32,
  parameter int DELAY = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [DW-1:0] i_sample,
  output logic [DW-1:0] o_sample
);

  logic [DELAY-1:0][DW-1:0] line_q;

  // Shift on each strobe; the output takes the oldest entry before it is overwritten.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      line_q   <= '0;
      o_sample <= '0;
    end else if (i_ce) begin
      o_sample <= line_q[DELAY-1];
      for (int i = DELAY - 1; i > 0; i--) begin
        line_q[i] <= line_q[i-1];
      end
      line_q[0] <= i_sample;
    end
  end

endmodule

// File: rtl/dsp_bypass_split.sv
// Feeds a bypassable filter and a matched bypass delay; o_en switches paths only when aligned.
// Latency: one clock on o_ce/o_fsample; o_bypass lags the input by DELAY strobes.
// Backpressure: none; every i_ce strobe is accepted, o_busy flags priming/flushing.
module dsp_bypass_split
  import dsp_bypass_split_pkg::*;
#(
  parameter int DW      = 32,
  parameter int LGDELAY = 4,
  parameter int DELAY   = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_ce,
  input  logic [DW-1:0] i_sample,
  output logic          o_ce,
  output logic [DW-1:0] o_fsample,
  output logic [DW-1:0] o_bypass,
  output logic          o_en,
  output logic          o_busy
);

  localparam int CW = cnt_width(LGDELAY);
  typedef logic [CW-1:0] cnt_t;

  // A strobe on the entry clock already counts toward the filter latency.
  localparam cnt_t LD_CE   = cnt_t'(DELAY - 1);
  localparam cnt_t LD_IDLE = cnt_t'(DELAY);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  cnt_t   ld_val;
  logic   en_d, busy_d;

  assign ld_val = i_ce ? LD_CE : LD_IDLE;

  // Next-state, counter and registered-output decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = o_en;
    busy_d  = o_busy;
    case (state_q)
      ST_BYPASS: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (i_en) begin
          if (ld_val == '0) begin
            state_d = ST_FILTER;
            en_d    = 1'b1;
          end else begin
            state_d = ST_PRIME;
            cnt_d   = ld_val;
            busy_d  = 1'b1;
          end
        end
      end
      ST_PRIME: begin
        if (!i_en) begin
          state_d = ST_BYPASS;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (i_ce) begin
          if (cnt_q == cnt_t'(1)) begin
            state_d = ST_FILTER;
            en_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
      end
      ST_FILTER: begin
        en_d   = 1'b1;
        busy_d = 1'b0;
        if (!i_en) begin
          if (ld_val == '0) begin
            state_d = ST_BYPASS;
            en_d    = 1'b0;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = ld_val;
            busy_d  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (i_en) begin
          // Zeros fed since flush entry are valid filter history; no re-prime needed.
          state_d = ST_FILTER;
          busy_d  = 1'b0;
        end else if (i_ce) begin
          if (cnt_q == cnt_t'(1)) begin
            state_d = ST_BYPASS;
            en_d    = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
      end
      default: begin
        state_d = ST_BYPASS;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state, latency counter and path-select outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_BYPASS;
      cnt_q   <= '0;
      o_en    <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_en    <= en_d;
      o_busy  <= busy_d;
    end
  end

  // Strobe forwarding and filter feed; zeros while bypassed flush the filter state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ce      <= 1'b0;
      o_fsample <= '0;
    end else begin
      o_ce <= i_ce;
      if (i_ce) begin
        o_fsample <= i_en ? i_sample : '0;
      end
    end
  end

  dsp_sample_delay #(
    .DW    (DW),
    .DELAY (DELAY)
  ) u_bypass_delay (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_ce     (i_ce),
    .i_sample (i_sample),
    .o_sample (o_bypass)
  );

endmodule
